// File: rtl/game_board_controller.sv
// Tic-tac-toe board controller: synchronised button edges, cursor, turn timer with auto-place,
// and win/draw evaluation.
module game_board_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_move,
  input  logic       btn_place,
  output logic [1:0] block00,
  output logic [1:0] block01,
  output logic [1:0] block02,
  output logic [1:0] block10,
  output logic [1:0] block11,
  output logic [1:0] block12,
  output logic [1:0] block20,
  output logic [1:0] block21,
  output logic [1:0] block22,
  output logic [3:0] selected,
  output logic [1:0] current_player,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam logic [31:0] TimerMax = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StPlay, StCheck, StOver} state_e;

  state_e          state;
  logic [8:0][1:0] cells;
  logic [31:0]     timer;

  logic move_s1, move_s2, move_h;
  logic place_s1, place_s2, place_h;
  logic move_press, place_press;

  logic       win, full, sel_empty;
  logic [3:0] first_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_s1  <= 1'b0;
      move_s2  <= 1'b0;
      move_h   <= 1'b0;
      place_s1 <= 1'b0;
      place_s2 <= 1'b0;
      place_h  <= 1'b0;
    end else begin
      move_s1  <= btn_move;
      move_s2  <= move_s1;
      move_h   <= move_s2;
      place_s1 <= btn_place;
      place_s2 <= place_s1;
      place_h  <= place_s2;
    end
  end

  assign move_press  = move_s2 & ~move_h;
  assign place_press = place_s2 & ~place_h;

  function automatic logic line_owned(input logic [8:0][1:0] b, input logic [1:0] p,
                                      input logic [3:0] a, input logic [3:0] x,
                                      input logic [3:0] y);
    return (b[a] == p) && (b[x] == p) && (b[y] == p);
  endfunction

  always_comb begin
    win = line_owned(cells, current_player, 4'd0, 4'd1, 4'd2) |
          line_owned(cells, current_player, 4'd3, 4'd4, 4'd5) |
          line_owned(cells, current_player, 4'd6, 4'd7, 4'd8) |
          line_owned(cells, current_player, 4'd0, 4'd3, 4'd6) |
          line_owned(cells, current_player, 4'd1, 4'd4, 4'd7) |
          line_owned(cells, current_player, 4'd2, 4'd5, 4'd8) |
          line_owned(cells, current_player, 4'd0, 4'd4, 4'd8) |
          line_owned(cells, current_player, 4'd2, 4'd4, 4'd6);
  end

  // Scan downwards so the lowest empty index is the one that sticks.
  always_comb begin
    full        = 1'b1;
    first_empty = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (cells[4'(i)] == 2'b00) begin
        full        = 1'b0;
        first_empty = 4'(i);
      end
    end
  end

  assign sel_empty = (cells[selected] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StPlay;
      cells          <= '0;
      selected       <= 4'd0;
      current_player <= 2'b01;
      winner         <= 2'b00;
      game_over      <= 1'b0;
      timer          <= '0;
    end else begin
      unique case (state)
        StPlay: begin
          if (place_press && sel_empty) begin
            cells[selected] <= current_player;
            state           <= StCheck;
          end else if (timer == TimerMax) begin
            cells[first_empty] <= current_player;
            state              <= StCheck;
          end else if (move_press) begin
            selected <= (selected == 4'd8) ? 4'd0 : selected + 4'd1;
            timer    <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        StCheck: begin
          timer <= '0;
          if (win) begin
            winner    <= current_player;
            game_over <= 1'b1;
            state     <= StOver;
          end else if (full) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
            state     <= StOver;
          end else begin
            current_player <= (current_player == 2'b01) ? 2'b10 : 2'b01;
            state          <= StPlay;
          end
        end
        StOver: begin
          timer <= '0;
          if (place_press) begin
            cells          <= '0;
            selected       <= 4'd0;
            current_player <= 2'b01;
            winner         <= 2'b00;
            game_over      <= 1'b0;
            state          <= StPlay;
          end
        end
        default: state <= StPlay;
      endcase
    end
  end

  assign block00 = cells[0];
  assign block01 = cells[1];
  assign block02 = cells[2];
  assign block10 = cells[3];
  assign block11 = cells[4];
  assign block12 = cells[5];
  assign block20 = cells[6];
  assign block21 = cells[7];
  assign block22 = cells[8];

endmodule
